// File: rtl/lab3_3_led_monitor_if.sv
// LED bus plus decoded monitor outputs for the lab3_3 bouncing-object animation.
// The animation side (master) drives the bus; the monitor (slave) drives the decode results.
interface lab3_3_led_monitor_if #(
  parameter int CNT_W = 8
);
  logic [15:0]      led;
  logic [3:0]       pos_a;
  logic [3:0]       pos_b;
  logic [3:0]       pos_m;
  logic             dir_a;
  logic             dir_b;
  logic             dir_m;
  logic [CNT_W-1:0] bounce_cnt;
  logic             upd;
  logic             locked;
  logic             err;

  modport master (
    output led,
    input  pos_a, pos_b, pos_m, dir_a, dir_b, dir_m, bounce_cnt, upd, locked, err
  );

  modport slave (
    input  led,
    output pos_a, pos_b, pos_m, dir_a, dir_b, dir_m, bounce_cnt, upd, locked, err
  );
endinterface

// File: rtl/lab3_3_led_monitor.sv
// Passive observer of the 16-bit lab3_3 LED bus: synchronizes it, accepts each new stable
// frame, decodes the positions of A, B and block M, tracks directions, counts bounces and
// raises a sticky error on illegal frames or on objects jumping more than one LED.
module lab3_3_led_monitor #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  lab3_3_led_monitor_if.slave  bus
);

  typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [15:0]      s1_q, s2_q, s3_q, last_q;
  logic [3:0]       pos_a_q, pos_a_d, pos_b_q, pos_b_d, pos_m_q, pos_m_d;
  logic             dir_a_q, dir_a_d, dir_b_q, dir_b_d, dir_m_q, dir_m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;

  logic             accept;
  logic [4:0]       pop;
  logic [3:0]       pa, pb, pm;
  logic [15:0]      rem;
  logic             legal;

  // An object moved up by one when new = old + 1, computed wide so 15 never wraps to 0.
  function automatic logic step_up(input logic [3:0] nw, input logic [3:0] od);
    return {1'b0, nw} == ({1'b0, od} + 5'd1);
  endfunction

  function automatic logic step_dn(input logic [3:0] nw, input logic [3:0] od);
    return ({1'b0, nw} + 5'd1) == {1'b0, od};
  endfunction

  // Frame decode of the synchronized bus: popcount, outer single LEDs, and the 3-LED block.
  always_comb begin
    pop = '0;
    pa  = '0;
    pb  = '0;
    pm  = '0;
    for (int i = 0; i < 16; i++) begin
      if (s2_q[i]) begin
        pa  = 4'(i);
        pop = pop + 5'd1;
      end
    end
    for (int i = 15; i >= 0; i--) begin
      if (s2_q[i]) pb = 4'(i);
    end
    rem = s2_q & ~(16'h0001 << pa) & ~(16'h0001 << pb);
    for (int i = 15; i >= 0; i--) begin
      if (rem[i]) pm = 4'(i);
    end
    legal = (pop == 5'd5) && (rem == (16'h0007 << pm)) && (pb < pm) &&
            (({1'b0, pm} + 5'd2) < {1'b0, pa});
  end

  assign accept = (s2_q == s3_q) && (s2_q != last_q);

  // Per-frame tracking: acquire positions, follow single steps, count reversals, flag errors.
  always_comb begin
    logic ua, da, ub, db, um, dm, jump;
    logic ba, bb, bm;
    logic [1:0]     nb;
    logic [CNT_W:0] sum;
    state_d = state_q;
    pos_a_d = pos_a_q;
    pos_b_d = pos_b_q;
    pos_m_d = pos_m_q;
    dir_a_d = dir_a_q;
    dir_b_d = dir_b_q;
    dir_m_d = dir_m_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    upd_d   = 1'b0;
    ua = step_up(pa, pos_a_q);
    da = step_dn(pa, pos_a_q);
    ub = step_up(pb, pos_b_q);
    db = step_dn(pb, pos_b_q);
    um = step_up(pm, pos_m_q);
    dm = step_dn(pm, pos_m_q);
    jump = (!(ua || da) && (pa != pos_a_q)) ||
           (!(ub || db) && (pb != pos_b_q)) ||
           (!(um || dm) && (pm != pos_m_q));
    ba = (ua && dir_a_q) || (da && !dir_a_q);
    bb = (ub && dir_b_q) || (db && !dir_b_q);
    bm = (um && dir_m_q) || (dm && !dir_m_q);
    nb  = {1'b0, ba} + {1'b0, bb} + {1'b0, bm};
    sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, nb};
    if (accept) begin
      upd_d = 1'b1;
      if (!legal) begin
        err_d   = 1'b1;
        state_d = ACQUIRE;
      end else begin
        pos_a_d = pa;
        pos_b_d = pb;
        pos_m_d = pm;
        state_d = TRACK;
        if (state_q == TRACK) begin
          if (jump) begin
            err_d = 1'b1;
          end else begin
            if (ua) dir_a_d = 1'b0;
            if (da) dir_a_d = 1'b1;
            if (ub) dir_b_d = 1'b0;
            if (db) dir_b_d = 1'b1;
            if (um) dir_m_d = 1'b0;
            if (dm) dir_m_d = 1'b1;
            cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
          end
        end
      end
    end
  end

  // Synchronizer chain, accepted-frame memory and all tracking state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      last_q  <= '0;
      state_q <= ACQUIRE;
      pos_a_q <= '0;
      pos_b_q <= '0;
      pos_m_q <= '0;
      dir_a_q <= 1'b1;
      dir_b_q <= 1'b0;
      dir_m_q <= 1'b1;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= bus.led;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      if (accept) last_q <= s2_q;
      state_q <= state_d;
      pos_a_q <= pos_a_d;
      pos_b_q <= pos_b_d;
      pos_m_q <= pos_m_d;
      dir_a_q <= dir_a_d;
      dir_b_q <= dir_b_d;
      dir_m_q <= dir_m_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign bus.pos_a      = pos_a_q;
  assign bus.pos_b      = pos_b_q;
  assign bus.pos_m      = pos_m_q;
  assign bus.dir_a      = dir_a_q;
  assign bus.dir_b      = dir_b_q;
  assign bus.dir_m      = dir_m_q;
  assign bus.bounce_cnt = cnt_q;
  assign bus.upd        = upd_q;
  assign bus.locked     = (state_q == TRACK);
  assign bus.err        = err_q;

endmodule
